// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef logic [15:0] data16_t;

  localparam int unsigned WAIT_CYCLES_DEF = 32'd1;

  // Zero the byte lanes whose enable is clear.
  function automatic data16_t mask_lanes(input data16_t d, input logic [1:0] be);
    mask_lanes = {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way grant logic with a last-grant pointer.
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = CLK ^ reset;

  // Port 0 always wins when both request.
  always_comb begin
    o_grant = 2'b00;
    if (!i_en) begin
      o_grant = 2'b00;
    end else if (i_req[0]) begin
      o_grant = 2'b01;
    end else if (i_req[1]) begin
      o_grant = 2'b10;
    end else begin
      o_grant = 2'b00;
    end
  end
`else
  logic r_last;

  // On a tie, grant the port that did not win last time.
  always_comb begin
    o_grant = 2'b00;
    if (!i_en) begin
      o_grant = 2'b00;
    end else if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_req;
    end
  end

  // Pointer moves only when a request is actually accepted.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[1];
    end else begin
      r_last <= r_last;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU/DMA) arbiter driving an asynchronous 16-bit SRAM with registered strobes.
// Build option: SRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [15:0]       p0_req_wdata,
  input  logic [1:0]        p0_req_be,
  output logic              p0_rsp_valid,
  output logic [15:0]       p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [15:0]       p1_req_wdata,
  input  logic [1:0]        p1_req_be,
  output logic              p1_rsp_valid,
  output logic [15:0]       p1_rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dat_write,
  input  logic [15:0]       sram_dat_read,
  output logic              sram_dat_oe,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic              r_port;
  logic              r_write;
  logic [1:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  data16_t           r_wdata;
  logic              r_cs_n, r_we_n, r_oe_n, r_ub_n, r_lb_n, r_dat_oe;
  logic [1:0]        r_rsp_valid;
  data16_t           r_rdata0, r_rdata1;

  logic              w_idle, w_accept, w_sel, w_write;
  logic [1:0]        w_grant, w_be;
  logic [ADDR_W-1:0] w_addr;
  data16_t           w_wdata;

  assign w_idle   = (r_state == ST_IDLE) && !reset;
  assign w_accept = |w_grant;
  assign w_sel    = w_grant[1];
  assign w_write  = w_sel ? p1_req_write : p0_req_write;
  assign w_addr   = w_sel ? p1_req_addr  : p0_req_addr;
  assign w_wdata  = w_sel ? p1_req_wdata : p0_req_wdata;
  assign w_be     = w_sel ? p1_req_be    : p0_req_be;

  sram_arb_rr u_rr (
    .CLK     (CLK),
    .reset   (reset),
    .i_en    (w_idle),
    .i_req   ({p1_req_valid, p0_req_valid}),
    .o_grant (w_grant)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one accept, WAIT_CYCLES+1 access cycles, one recovery cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_ACCESS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 3'd0) begin
          w_next = ST_RECOVER;
        end else begin
          w_next = ST_ACCESS;
        end
      end
      ST_RECOVER: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Strobes are loaded on the edge that enters each state so the pads see clean registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt       <= 3'd0;
      r_port      <= 1'b0;
      r_write     <= 1'b0;
      r_be        <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= 16'h0000;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_dat_oe    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rdata0    <= 16'h0000;
      r_rdata1    <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 2'b00;
          if (w_accept) begin
            r_port   <= w_sel;
            r_write  <= w_write;
            r_be     <= w_be;
            r_cnt    <= WAIT_LD;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_cs_n   <= 1'b0;
            r_we_n   <= ~w_write;
            r_oe_n   <= w_write;
            r_ub_n   <= ~w_be[1];
            r_lb_n   <= ~w_be[0];
            r_dat_oe <= w_write;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 3'd0) begin
            // Release strobes; address, data and dat_oe stay put for hold time.
            r_cs_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_rsp_valid <= r_port ? 2'b10 : 2'b01;
            if (!r_write && r_port) begin
              r_rdata1 <= mask_lanes(sram_dat_read, r_be);
            end else if (!r_write) begin
              r_rdata0 <= mask_lanes(sram_dat_read, r_be);
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RECOVER: begin
          r_rsp_valid <= 2'b00;
          r_dat_oe    <= 1'b0;
        end
        default: begin
          r_cs_n      <= 1'b1;
          r_we_n      <= 1'b1;
          r_oe_n      <= 1'b1;
          r_ub_n      <= 1'b1;
          r_lb_n      <= 1'b1;
          r_dat_oe    <= 1'b0;
          r_rsp_valid <= 2'b00;
        end
      endcase
    end
  end

  assign p0_req_ready   = w_grant[0];
  assign p1_req_ready   = w_grant[1];
  assign p0_rsp_valid   = r_rsp_valid[0];
  assign p1_rsp_valid   = r_rsp_valid[1];
  assign p0_rsp_rdata   = r_rdata0;
  assign p1_rsp_rdata   = r_rdata1;
  assign sram_addr      = r_addr;
  assign sram_dat_write = r_wdata;
  assign sram_dat_oe    = r_dat_oe;
  assign sram_cs_n      = r_cs_n;
  assign sram_we_n      = r_we_n;
  assign sram_oe_n      = r_oe_n;
  assign sram_ub_n      = r_ub_n;
  assign sram_lb_n      = r_lb_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (WAIT_CYCLES 0, 1, 7), a behavioural SRAM per instance,
// and a transaction-level reference model of the expected strobe timeline.
module tb_sram_arbiter;

  localparam int NI = 3;
  localparam int AW = 18;

  int waits [NI] = '{0, 1, 7};

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic          v   [NI][2];
  logic          wr  [NI][2];
  logic [AW-1:0] a   [NI][2];
  logic [15:0]   wd  [NI][2];
  logic [1:0]    be  [NI][2];
  logic          rdy0 [NI], rdy1 [NI], rv0 [NI], rv1 [NI];
  logic [15:0]   rd0 [NI], rd1 [NI];
  logic [AW-1:0] s_addr [NI];
  logic [15:0]   s_wd [NI], s_rd [NI];
  logic          s_oe [NI], cs_n [NI], we_n [NI], oe_n [NI], ub_n [NI], lb_n [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
    logic [15:0] mem [256];

    sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(AW)) u_dut (
      .CLK(CLK), .reset(reset),
      .p0_req_valid(v[g][0]), .p0_req_ready(rdy0[g]), .p0_req_write(wr[g][0]),
      .p0_req_addr(a[g][0]), .p0_req_wdata(wd[g][0]), .p0_req_be(be[g][0]),
      .p0_rsp_valid(rv0[g]), .p0_rsp_rdata(rd0[g]),
      .p1_req_valid(v[g][1]), .p1_req_ready(rdy1[g]), .p1_req_write(wr[g][1]),
      .p1_req_addr(a[g][1]), .p1_req_wdata(wd[g][1]), .p1_req_be(be[g][1]),
      .p1_rsp_valid(rv1[g]), .p1_rsp_rdata(rd1[g]),
      .sram_addr(s_addr[g]), .sram_dat_write(s_wd[g]), .sram_dat_read(s_rd[g]),
      .sram_dat_oe(s_oe[g]), .sram_cs_n(cs_n[g]), .sram_we_n(we_n[g]),
      .sram_oe_n(oe_n[g]), .sram_ub_n(ub_n[g]), .sram_lb_n(lb_n[g])
    );

    assign s_rd[g] = mem[s_addr[g][7:0]];

    // Behavioural SRAM: byte-lane writes while CS and WE are low.
    always @(posedge CLK) begin
      if (reset) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      end else if (!cs_n[g] && !we_n[g]) begin
        if (!ub_n[g]) mem[s_addr[g][7:0]][15:8] <= s_wd[g][15:8];
        if (!lb_n[g]) mem[s_addr[g][7:0]][7:0]  <= s_wd[g][7:0];
      end
    end
  end

  logic [15:0] ref_mem [NI][256];
  logic [15:0] exp_rd  [NI][2];
  int checks = 0;
  int errors = 0;

  logic [7:0]    rec_strb [12];
  logic [AW-1:0] rec_addr [12];
  logic [15:0]   rec_wd   [12];
  logic [15:0]   rec_rd   [12][2];
  logic [1:0]    rec_rdy;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] strb(input int k);
    return {cs_n[k], we_n[k], oe_n[k], ub_n[k], lb_n[k], s_oe[k], rv0[k], rv1[k]};
  endfunction

  task automatic reset_model;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 16'h0000;
      exp_rd[k][0] = 16'h0000;
      exp_rd[k][1] = 16'h0000;
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_model();
  endtask

  // Transaction-level model: writes update enabled lanes, reads return masked memory.
  task automatic model_update(input int k, input int p, input logic w, input logic [AW-1:0] ad,
                              input logic [15:0] d, input logic [1:0] b);
    if (w) begin
      if (b[1]) ref_mem[k][ad[7:0]][15:8] = d[15:8];
      if (b[0]) ref_mem[k][ad[7:0]][7:0]  = d[7:0];
    end else begin
      exp_rd[k][p] = {(b[1] ? ref_mem[k][ad[7:0]][15:8] : 8'h00),
                      (b[0] ? ref_mem[k][ad[7:0]][7:0]  : 8'h00)};
    end
  endtask

  // Issue one request in the current cycle and record cycles 0..W+3 (no checking here).
  task automatic do_access(input int k, input int p, input logic w, input logic [AW-1:0] ad,
                           input logic [15:0] d, input logic [1:0] b);
    v[k][p] = 1'b1; wr[k][p] = w; a[k][p] = ad; wd[k][p] = d; be[k][p] = b;
    #1;
    rec_rdy = {rdy1[k], rdy0[k]};
    rec_strb[0] = strb(k); rec_addr[0] = s_addr[k]; rec_wd[0] = s_wd[k];
    rec_rd[0][0] = rd0[k]; rec_rd[0][1] = rd1[k];
    tick();
    v[k][p] = 1'b0;
    for (int c = 1; c <= waits[k] + 3; c++) begin
      rec_strb[c] = strb(k); rec_addr[c] = s_addr[k]; rec_wd[c] = s_wd[k];
      rec_rd[c][0] = rd0[k]; rec_rd[c][1] = rd1[k];
      if (c < waits[k] + 3) tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (strb(k) !== 8'b11111000) begin
        errors++; $display("FAIL reset_strobes k=%0d got=%b exp=%b", k, strb(k), 8'b11111000);
      end
      checks++;
      if ({s_addr[k], s_wd[k], rd0[k], rd1[k]} !== '0) begin
        errors++; $display("FAIL reset_data k=%0d addr=%h wd=%h rd0=%h rd1=%h exp=0",
                           k, s_addr[k], s_wd[k], rd0[k], rd1[k]);
      end
    end
    reset = 1'b0;
    reset_model();
    tick();
  endtask

  task automatic test_write;
    do_access(1, 0, 1'b1, 18'h00010, 16'hBEEF, 2'b11);
    model_update(1, 0, 1'b1, 18'h00010, 16'hBEEF, 2'b11);
    checks++;
    if (rec_rdy !== 2'b01) begin
      errors++; $display("FAIL write_ready got=%b exp=01", rec_rdy);
    end
    for (int c = 0; c <= 4; c++) begin
      logic [2:0] e, o;
      e = {((c == 1) || (c == 2)) ? 1'b0 : 1'b1, (c >= 1) && (c <= 3), c == 3};
      o = {rec_strb[c][6], rec_strb[c][2], rec_strb[c][1]};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL write_timeline c=%0d we_n/dat_oe/rsp got=%b exp=%b", c, o, e);
      end
    end
    checks++;
    if ({rec_addr[2], rec_wd[2], rec_addr[3], rec_wd[3]} !== {18'h00010, 16'hBEEF, 18'h00010, 16'hBEEF}) begin
      errors++; $display("FAIL write_pads addr=%h wd=%h exp=00010/beef", rec_addr[3], rec_wd[3]);
    end
    checks++;
    if (g_dut[1].mem[16] !== 16'hBEEF) begin
      errors++; $display("FAIL write_mem got=%h exp=beef", g_dut[1].mem[16]);
    end
  endtask

  task automatic test_read;
    do_access(1, 0, 1'b1, 18'h00020, 16'h1234, 2'b11);
    model_update(1, 0, 1'b1, 18'h00020, 16'h1234, 2'b11);
    do_access(1, 1, 1'b0, 18'h00020, 16'h0000, 2'b01);
    model_update(1, 1, 1'b0, 18'h00020, 16'h0000, 2'b01);
    checks++;
    if (rec_rdy !== 2'b10) begin
      errors++; $display("FAIL read_ready got=%b exp=10", rec_rdy);
    end
    for (int c = 0; c <= 4; c++) begin
      logic [1:0] e, o;
      e = {((c == 1) || (c == 2)) ? 1'b0 : 1'b1, c == 3};
      o = {rec_strb[c][5], rec_strb[c][0]};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL read_timeline c=%0d oe_n/p1_rsp got=%b exp=%b", c, o, e);
      end
    end
    checks++;
    if ({rec_rd[3][1], rec_rd[4][1]} !== {16'h0034, 16'h0034}) begin
      errors++; $display("FAIL read_rdata c3=%h c4=%h exp=0034", rec_rd[3][1], rec_rd[4][1]);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 24; n++) begin
        int p, W;
        logic w;
        logic [AW-1:0] ad;
        logic [15:0] d;
        logic [1:0] b;
        p  = int'($urandom_range(0, 1));
        w  = 1'($urandom_range(0, 1));
        ad = AW'($urandom);
        d  = 16'($urandom);
        b  = 2'($urandom_range(0, 3));
        W  = waits[k];
        do_access(k, p, w, ad, d, b);
        model_update(k, p, w, ad, d, b);
        checks++;
        if (rec_rdy !== ((p == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rand_ready k=%0d n=%0d got=%b p=%0d", k, n, rec_rdy, p);
        end
        for (int c = 0; c <= W + 3; c++) begin
          logic [7:0] e;
          if ((c == 0) || (c == W + 3)) e = 8'b11111000;
          else if (c <= W + 1)         e = {1'b0, ~w, w, ~b[1], ~b[0], w, 2'b00};
          else                         e = {5'b11111, w, p == 0, p == 1};
          checks++;
          if (rec_strb[c] !== e) begin
            errors++; $display("FAIL rand_strobes k=%0d n=%0d c=%0d got=%b exp=%b", k, n, c, rec_strb[c], e);
          end
          if ((c >= 1) && (c <= W + 2)) begin
            checks++;
            if ((rec_addr[c] !== ad) || (w && (rec_wd[c] !== d))) begin
              errors++; $display("FAIL rand_pads k=%0d n=%0d c=%0d addr=%h exp=%h wd=%h exp=%h",
                                 k, n, c, rec_addr[c], ad, rec_wd[c], d);
            end
          end
          if (c >= W + 2) begin
            checks++;
            if ((rec_rd[c][0] !== exp_rd[k][0]) || (rec_rd[c][1] !== exp_rd[k][1])) begin
              errors++; $display("FAIL rand_rdata k=%0d n=%0d c=%0d got=%h/%h exp=%h/%h",
                                 k, n, c, rec_rd[c][0], rec_rd[c][1], exp_rd[k][0], exp_rd[k][1]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < NI; k++) begin
      int t0, t1, acc;
      logic [AW-1:0] ad;
      t0 = -1; t1 = -1; acc = 0;
      ad = AW'($urandom);
      v[k][0] = 1'b1; wr[k][0] = 1'b0; a[k][0] = ad; be[k][0] = 2'b11;
      for (int c = 0; (c < 60) && (t1 < 0); c++) begin
        #1;
        if (rdy0[k] && (t0 < 0)) t0 = c;
        else if (rdy0[k]) t1 = c;
        if ((t0 >= 0) && !cs_n[k]) acc++;
        tick();
      end
      v[k][0] = 1'b0;
      model_update(k, 0, 1'b0, ad, 16'h0000, 2'b11);
      for (int c = 0; c < waits[k] + 2; c++) tick();
      checks++;
      if ((t1 - t0) !== (waits[k] + 3)) begin
        errors++; $display("FAIL b2b_spacing k=%0d got=%0d exp=%0d", k, t1 - t0, waits[k] + 3);
      end
      checks++;
      if (acc !== (waits[k] + 1)) begin
        errors++; $display("FAIL b2b_access_len k=%0d got=%0d exp=%0d", k, acc, waits[k] + 1);
      end
    end
  endtask

  task automatic test_contention;
    int grants [$];
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      v[1][p] = 1'b1; wr[1][p] = 1'b0; a[1][p] = 18'h00000; be[1][p] = 2'b11;
    end
    for (int c = 0; (c < 200) && (grants.size() < 6); c++) begin
      #1;
      checks++;
      if (rdy0[1] && rdy1[1]) begin
        errors++; $display("FAIL cont_onehot c=%0d got=11 exp=at most one ready", c);
      end
      if (rdy0[1]) grants.push_back(0);
      else if (rdy1[1]) grants.push_back(1);
      tick();
    end
    v[1][0] = 1'b0; v[1][1] = 1'b0;
    for (int c = 0; c < waits[1] + 2; c++) tick();
    checks++;
    if (grants.size() !== 6) begin
      errors++; $display("FAIL cont_count got=%0d exp=6", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      int e;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = i % 2;
`endif
      checks++;
      if (grants[i] !== e) begin
        errors++; $display("FAIL cont_grant i=%0d got=%0d exp=%0d", i, grants[i], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    v[1][0] = 1'b1; wr[1][0] = 1'b1; a[1][0] = 18'h00033; wd[1][0] = 16'($urandom); be[1][0] = 2'b11;
    #1;
    checks++;
    if (rdy0[1] !== 1'b1) begin
      errors++; $display("FAIL mid_accept got=%b exp=1", rdy0[1]);
    end
    tick();
    v[1][0] = 1'b0;
    tick();
    checks++;
    if (cs_n[1] !== 1'b0) begin
      errors++; $display("FAIL mid_in_access cs_n got=%b exp=0", cs_n[1]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_model();
    checks++;
    if (strb(1) !== 8'b11111000) begin
      errors++; $display("FAIL mid_abort_strobes got=%b exp=11111000", strb(1));
    end
    tick();
    checks++;
    if (strb(1) !== 8'b11111000) begin
      errors++; $display("FAIL mid_no_rsp got=%b exp=11111000", strb(1));
    end
    do_access(1, 0, 1'b0, 18'h00033, 16'h0000, 2'b11);
    model_update(1, 0, 1'b0, 18'h00033, 16'h0000, 2'b11);
    checks++;
    if ({rec_rdy, rec_strb[1][7], rec_strb[3][1]} !== 4'b0101) begin
      errors++; $display("FAIL mid_new_req rdy=%b cs_n=%b rsp=%b exp=01/0/1",
                         rec_rdy, rec_strb[1][7], rec_strb[3][1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        v[k][p] = 1'b0; wr[k][p] = 1'b0; a[k][p] = '0; wd[k][p] = 16'h0000; be[k][p] = 2'b00;
      end
    end
    reset_model();
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM access cycles beyond the first, range 0..7.
REQ-002 SHALL have parameter ADDR_W, default 18: SRAM word-address width.
REQ-003 SHALL have ports:
- CLK  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- pN_req_valid  in  1  request from port N (N=0 CPU, N=1 DMA).
- pN_req_ready  out  1  request accepted this cycle.
- pN_req_write  in  1  1=write, 0=read.
- pN_req_addr  in  ADDR_W  word address.
- pN_req_wdata  in  16  write data.
- pN_req_be  in  2  byte enables; bit1 upper, bit0 lower.
- pN_rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
- pN_rsp_rdata  out  16  read data, valid with pN_rsp_valid.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dat_write  out  16  data to pad.
- sram_dat_read  in  16  data from pad.
- sram_dat_oe  out  1  pad output enable.
- sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Function
REQ-004 SHALL implement the FSM states IDLE, ACCESS and RECOVER.
REQ-005 In IDLE with at least one pN_req_valid asserted, SHALL assert exactly one pN_req_ready combinationally, latch that port's addr/wdata/be/write, and go to ACCESS.
REQ-006 Round-robin arbitration: when both ports are valid, grant the port not granted last; the last-grant pointer updates only on acceptance.
REQ-007 SHALL stay in ACCESS for exactly WAIT_CYCLES+1 cycles with:
- sram_cs_n=0;
- ub_n/lb_n = ~be;
- read: oe_n=0, we_n=1, dat_oe=0;
- write: oe_n=1, we_n=0, dat_oe=1.
REQ-008 On the final ACCESS cycle of a read, SHALL register sram_dat_read into the rsp_rdata register; lanes with be=0 read as 0x00.
REQ-009 RECOVER SHALL last exactly 1 cycle with:
- cs_n=we_n=oe_n=ub_n=lb_n=1;
- sram_addr and sram_dat_write held;
- dat_oe held for a write (data hold after WE rise);
- the granted pN_rsp_valid pulsed.
RECOVER always returns to IDLE.
REQ-010 Latency: accept at cycle 0, rsp_valid at cycle WAIT_CYCLES+2; one access per WAIT_CYCLES+3 cycles.
REQ-011 pN_req_ready SHALL be 0 outside IDLE; a requester holds valid and payload until ready.
REQ-012 An access with be=2'b00 SHALL still run the full sequence, with ub_n=lb_n=1 and rsp_valid asserted.
REQ-013 The ACCESS wait counter SHALL be 3 bits, SHALL load WAIT_CYCLES on entry, and exit at 0 with no wrap-around.
REQ-014 pN_rsp_rdata SHALL hold its value until the next read response to that port.

Reset
REQ-015 On reset, the next edge SHALL produce:
- state IDLE;
- all sram_*_n = 1, dat_oe = 0;
- sram_addr = 0, sram_dat_write = 0;
- rsp_valid = 0, rsp_rdata = 0;
- round-robin pointer = 1, so port 0 wins first.
REQ-016 Reset mid-ACCESS SHALL abort the access with no rsp_valid; the aborted request is lost.

Configuration
REQ-017 Macro SRAM_ARB_FIXED_PRIO_EN:
- defined: port 0 always wins simultaneous requests and the pointer is unused.
- undefined: round-robin per REQ-006.

Structure
REQ-018 A shared package sram_arb_pkg SHALL hold the FSM state enum, the 16-bit data type, and the default WAIT_CYCLES constant.
REQ-019 A single sub-module sram_arb_rr SHALL provide the 2-way grant logic with pointer; it is compiled to fixed priority under REQ-017.

Verification
REQ-020 Write: WAIT_CYCLES=1, p0 write addr 0x00010, data 0xBEEF, be=11 -> we_n low for cycles 1-2, dat_oe=1 for cycles 1-3, p0_rsp_valid at cycle 3.
REQ-021 Read: model returns 0x1234, p1 read with be=01 -> p1_rsp_rdata=0x0034 at cycle 3 and oe_n low for cycles 1-2.
REQ-022 Contention: both ports valid every cycle for 6 accesses -> grants alternate 0,1,0,1,0,1; with SRAM_ARB_FIXED_PRIO_EN defined, all grants go to port 0.
REQ-023 WAIT_CYCLES=0 and WAIT_CYCLES=7 -> ACCESS lasts 1 and 8 cycles respectively, and back-to-back accesses are spaced 3 and 10 cycles apart.
REQ-024 Reset on the second ACCESS cycle -> next cycle all strobes=1, dat_oe=0, no rsp_valid, and a new p0 request is accepted on the following cycle.
